// File: rtl/rv64_pkg.sv
// Shared RV64 constants: datapath width, writeback source encodings and load funct3 codes.
// Also holds the load alignment rule used by the writeback stage.
package rv64_pkg;

  localparam int XLEN = 64;

  typedef enum logic [1:0] {
    WB_ALU  = 2'b00,
    WB_LOAD = 2'b01,
    WB_PC4  = 2'b10,
    WB_IMM  = 2'b11
  } wbsel_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;
  localparam logic [2:0] F3_LDX = 3'b111;

  // Byte loads can never be misaligned; 111 follows the doubleword rule.
  function automatic logic load_misaligned(input logic [2:0] funct3, input logic [2:0] addr_lo);
    logic mis;
    mis = 1'b0;
    case (funct3)
      F3_LH, F3_LHU:  mis = addr_lo[0];
      F3_LW, F3_LWU:  mis = |addr_lo[1:0];
      F3_LD, F3_LDX:  mis = |addr_lo;
      default:        mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/load_extend.sv
// Combinational load data alignment and sign/zero extension for RV64 loads.
// The raw doubleword is shifted down by the byte offset, then extended by funct3.
module load_extend
  import rv64_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [XLEN-1:0] i_raw,
  input  logic [2:0]      i_funct3,
  input  logic [2:0]      i_addr_lo,
  output logic [XLEN-1:0] o_data
);

  logic        [XLEN-1:0] w_shift;
  logic signed [XLEN-1:0] w_sb;
  logic signed [XLEN-1:0] w_sh;
  logic signed [XLEN-1:0] w_sw;
  logic        [XLEN-1:0] w_ub;
  logic        [XLEN-1:0] w_uh;
  logic        [XLEN-1:0] w_uw;

  assign w_shift = i_raw >> {i_addr_lo, 3'b000};

  assign w_sb = {{(XLEN-8){w_shift[7]}},   w_shift[7:0]};
  assign w_sh = {{(XLEN-16){w_shift[15]}}, w_shift[15:0]};
  assign w_sw = {{(XLEN-32){w_shift[31]}}, w_shift[31:0]};
  assign w_ub = {{(XLEN-8){1'b0}},  w_shift[7:0]};
  assign w_uh = {{(XLEN-16){1'b0}}, w_shift[15:0]};
  assign w_uw = {{(XLEN-32){1'b0}}, w_shift[31:0]};

  always_comb begin
    o_data = w_shift;
    case (i_funct3)
      F3_LB:   o_data = w_sb;
      F3_LH:   o_data = w_sh;
      F3_LW:   o_data = w_sw;
      F3_LBU:  o_data = w_ub;
      F3_LHU:  o_data = w_uh;
      F3_LWU:  o_data = w_uw;
      default: o_data = w_shift;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// RV64 writeback stage: MEM/WB stage register, writeback source mux, load extension,
// misaligned-load detection and the retired-instruction counter.
module wb_stage
  import rv64_pkg::*;
#(
  parameter int XLEN = rv64_pkg::XLEN
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  input  logic            stall,
  input  logic            flush,
  input  logic            in_regwrite,
  input  logic [4:0]      in_rd,
  input  logic [1:0]      in_wbsel,
  input  logic [XLEN-1:0] in_alu_result,
  input  logic [XLEN-1:0] in_load_data,
  input  logic [2:0]      in_funct3,
  input  logic [2:0]      in_addr_lo,
  input  logic [XLEN-1:0] in_pc_plus4,
  input  logic [XLEN-1:0] in_imm,
  output logic            write,
  output logic [4:0]      writenum,
  output logic [XLEN-1:0] write_data,
  output logic            misalign_err,
  output logic [63:0]     instret
);

  logic            r_valid;
  logic            r_regwrite;
  logic [4:0]      r_rd;
  wbsel_e          r_wbsel;
  logic [XLEN-1:0] r_alu;
  logic [XLEN-1:0] r_load;
  logic [2:0]      r_funct3;
  logic [2:0]      r_addr_lo;
  logic [XLEN-1:0] r_pc4;
  logic [XLEN-1:0] r_imm;
  logic [63:0]     r_instret;

  logic [XLEN-1:0] w_load_ext;
  logic            w_misalign;
  logic            w_retire;

  // Stage register: flush beats stall; reset squashes whatever is held.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid    <= 1'b0;
      r_regwrite <= 1'b0;
      r_rd       <= '0;
      r_wbsel    <= WB_ALU;
      r_alu      <= '0;
      r_load     <= '0;
      r_funct3   <= '0;
      r_addr_lo  <= '0;
      r_pc4      <= '0;
      r_imm      <= '0;
    end else if (flush) begin
      r_valid    <= 1'b0;
    end else if (!stall) begin
      r_valid    <= in_valid;
      r_regwrite <= in_regwrite;
      r_rd       <= in_rd;
      r_wbsel    <= wbsel_e'(in_wbsel);
      r_alu      <= in_alu_result;
      r_load     <= in_load_data;
      r_funct3   <= in_funct3;
      r_addr_lo  <= in_addr_lo;
      r_pc4      <= in_pc_plus4;
      r_imm      <= in_imm;
    end
  end

  load_extend #(.XLEN(XLEN)) u_load_extend (
    .i_raw     (r_load),
    .i_funct3  (r_funct3),
    .i_addr_lo (r_addr_lo),
    .o_data    (w_load_ext)
  );

  assign w_misalign = r_valid && (r_wbsel == WB_LOAD) && load_misaligned(r_funct3, r_addr_lo);
  assign w_retire   = r_valid && !stall && !w_misalign;

  always_comb begin
    write_data = r_alu;
    case (r_wbsel)
      WB_ALU:  write_data = r_alu;
      WB_LOAD: write_data = w_load_ext;
      WB_PC4:  write_data = r_pc4;
      WB_IMM:  write_data = r_imm;
      default: write_data = r_alu;
    endcase
  end

  assign write        = r_valid && r_regwrite && (r_rd != 5'd0) && !w_misalign && !stall;
  assign writenum     = r_rd;
  assign misalign_err = w_misalign;

  // Retirement counter: counts every completed instruction, including x0 and non-writing ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_instret <= '0;
    end else if (w_retire) begin
      r_instret <= r_instret + 64'd1;
    end
  end

  assign instret = r_instret;

endmodule

// File: tb/tb_wb_stage.sv
// Directed self-checking bench for wb_stage with a small register-file model fed by write.
module tb_wb_stage;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        stall;
  logic        flush;
  logic        in_regwrite;
  logic [4:0]  in_rd;
  logic [1:0]  in_wbsel;
  logic [63:0] in_alu_result;
  logic [63:0] in_load_data;
  logic [2:0]  in_funct3;
  logic [2:0]  in_addr_lo;
  logic [63:0] in_pc_plus4;
  logic [63:0] in_imm;
  logic        write;
  logic [4:0]  writenum;
  logic [63:0] write_data;
  logic        misalign_err;
  logic [63:0] instret;

  int n_checks;
  int n_errors;

  logic [63:0] rf [32];

  wb_stage #(.XLEN(64)) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .stall         (stall),
    .flush         (flush),
    .in_regwrite   (in_regwrite),
    .in_rd         (in_rd),
    .in_wbsel      (in_wbsel),
    .in_alu_result (in_alu_result),
    .in_load_data  (in_load_data),
    .in_funct3     (in_funct3),
    .in_addr_lo    (in_addr_lo),
    .in_pc_plus4   (in_pc_plus4),
    .in_imm        (in_imm),
    .write         (write),
    .writenum      (writenum),
    .write_data    (write_data),
    .misalign_err  (misalign_err),
    .instret       (instret)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else if (write) begin
      rf[writenum] <= write_data;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_in(input logic v, input logic rw, input logic [4:0] rd,
                        input logic [1:0] sel, input logic [63:0] alu,
                        input logic [63:0] ld, input logic [2:0] f3, input logic [2:0] alo);
    @(negedge clk);
    in_valid      = v;
    in_regwrite   = rw;
    in_rd         = rd;
    in_wbsel      = sel;
    in_alu_result = alu;
    in_load_data  = ld;
    in_funct3     = f3;
    in_addr_lo    = alo;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1;
    stall = 1'b0;
    flush = 1'b0;
    in_valid = 1'b0;
    in_regwrite = 1'b0;
    in_rd = '0;
    in_wbsel = '0;
    in_alu_result = '0;
    in_load_data = '0;
    in_funct3 = '0;
    in_addr_lo = '0;
    in_pc_plus4 = 64'h0000_0000_0000_1004;
    in_imm = 64'h0000_0000_1234_5000;

    #12;
    chk("rst_write", {63'd0, write}, 64'd0);
    chk("rst_writenum", {59'd0, writenum}, 64'd0);
    chk("rst_data", write_data, 64'd0);
    chk("rst_mis", {63'd0, misalign_err}, 64'd0);
    chk("rst_instret", instret, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // ALU writeback to x1
    set_in(1, 1, 5'd1, 2'b00, 64'd42, 64'd0, 3'd0, 3'd0);
    tick();
    chk("alu_write", {63'd0, write}, 64'd1);
    chk("alu_writenum", {59'd0, writenum}, 64'd1);
    chk("alu_data", write_data, 64'd42);
    set_in(0, 0, 5'd0, 2'b00, 64'd0, 64'd0, 3'd0, 3'd0);
    tick();
    chk("alu_rf_x1", rf[1], 64'd42);
    chk("alu_instret", instret, 64'd1);
    chk("bubble_write", {63'd0, write}, 64'd0);

    // LB then LBU of byte 1 = 0x80
    set_in(1, 1, 5'd2, 2'b01, 64'd0, 64'h0000_0000_0000_8000, 3'b000, 3'd1);
    tick();
    chk("lb_data", write_data, 64'hFFFF_FFFF_FFFF_FF80);
    chk("lb_write", {63'd0, write}, 64'd1);
    chk("lb_mis", {63'd0, misalign_err}, 64'd0);
    set_in(1, 1, 5'd3, 2'b01, 64'd0, 64'h0000_0000_0000_8000, 3'b100, 3'd1);
    tick();
    chk("lbu_data", write_data, 64'h0000_0000_0000_0080);
    chk("lb_instret", instret, 64'd2);
    set_in(0, 0, 5'd0, 2'b00, 64'd0, 64'd0, 3'd0, 3'd0);
    tick();
    chk("lbu_instret", instret, 64'd3);
    chk("lb_rf_x2", rf[2], 64'hFFFF_FFFF_FFFF_FF80);

    // Misaligned LW at offset 2
    set_in(1, 1, 5'd4, 2'b01, 64'd0, 64'h1122_3344_5566_7788, 3'b010, 3'd2);
    tick();
    chk("lw_mis", {63'd0, misalign_err}, 64'd1);
    chk("lw_write", {63'd0, write}, 64'd0);
    set_in(0, 0, 5'd0, 2'b00, 64'd0, 64'd0, 3'd0, 3'd0);
    tick();
    chk("lw_instret", instret, 64'd3);
    chk("lw_rf_x4", rf[4], 64'd0);

    // x0 target: no write but retires
    set_in(1, 1, 5'd0, 2'b00, 64'd100, 64'd0, 3'd0, 3'd0);
    tick();
    chk("x0_write", {63'd0, write}, 64'd0);
    set_in(0, 0, 5'd0, 2'b00, 64'd0, 64'd0, 3'd0, 3'd0);
    tick();
    chk("x0_instret", instret, 64'd4);

    // Stall held three cycles over an ALU op to x5
    set_in(1, 1, 5'd5, 2'b00, 64'd7, 64'd0, 3'd0, 3'd0);
    tick();
    chk("pre_stall_write", {63'd0, write}, 64'd1);
    set_in(1, 1, 5'd6, 2'b00, 64'd99, 64'd0, 3'd0, 3'd0);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_write", {63'd0, write}, 64'd0);
      chk("stall_instret", instret, 64'd4);
      chk("stall_writenum", {59'd0, writenum}, 64'd5);
    end
    set_in(0, 0, 5'd0, 2'b00, 64'd0, 64'd0, 3'd0, 3'd0);
    stall = 1'b0;
    #1;
    chk("unstall_write", {63'd0, write}, 64'd1);
    chk("unstall_data", write_data, 64'd7);
    tick();
    chk("unstall_instret", instret, 64'd5);
    chk("unstall_rf_x5", rf[5], 64'd7);
    chk("unstall_rf_x6", rf[6], 64'd0);

    // Flush together with stall squashes the held op to x8
    set_in(1, 1, 5'd8, 2'b00, 64'd9, 64'd0, 3'd0, 3'd0);
    tick();
    chk("pre_flush_write", {63'd0, write}, 64'd1);
    @(negedge clk);
    stall = 1'b1;
    flush = 1'b1;
    tick();
    set_in(0, 0, 5'd0, 2'b00, 64'd0, 64'd0, 3'd0, 3'd0);
    stall = 1'b0;
    flush = 1'b0;
    #1;
    chk("flush_write", {63'd0, write}, 64'd0);
    tick();
    chk("flush_instret", instret, 64'd5);
    chk("flush_rf_x8", rf[8], 64'd0);

    // PC+4 source, then async reset between edges
    set_in(1, 1, 5'd9, 2'b10, 64'd0, 64'd0, 3'd0, 3'd0);
    tick();
    chk("pc4_data", write_data, 64'h0000_0000_0000_1004);
    chk("pc4_write", {63'd0, write}, 64'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_write", {63'd0, write}, 64'd0);
    chk("midrst_writenum", {59'd0, writenum}, 64'd0);
    chk("midrst_data", write_data, 64'd0);
    chk("midrst_instret", instret, 64'd0);
    set_in(0, 0, 5'd0, 2'b00, 64'd0, 64'd0, 3'd0, 3'd0);
    rst = 1'b0;
    tick();
    chk("postrst_instret", instret, 64'd0);
    chk("postrst_rf_x9", rf[9], 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
